// File: rtl/alu_mp_seq_pkg.sv
// Shared types for the multi-precision sequencer and its byte ALU.
// Holds the command opcode, sequencer state and ALU control encodings.
package alu_mp_seq_pkg;

    typedef enum logic {
        MP_ADD,
        MP_SUB
    } MP_OP;

    typedef enum {
        MP_IDLE,
        MP_RUN,
        MP_DONE
    } mp_state_t;

    typedef enum logic {
        ALU_ADD,
        ALU_ADDC
    } ALU_CTRL;

endpackage

// File: rtl/alu_mp_seq_if.sv
// Command/result handshake bundle for the multi-precision sequencer.
// master: issues commands, consumes results; slave: the sequencer.
interface alu_mp_seq_if
    import alu_mp_seq_pkg::*;
#(
    parameter int NBYTES = 4
);
    logic                  start_valid;
    logic                  start_ready;
    MP_OP                  op;
    logic [8*NBYTES-1:0]   a_in;
    logic [8*NBYTES-1:0]   b_in;
    logic [8*NBYTES-1:0]   result;
    logic                  carry_out;
    logic                  zero;
    logic                  done_valid;
    logic                  done_ready;

    modport master (
        output start_valid, op, a_in, b_in, done_ready,
        input  start_ready, result, carry_out, zero, done_valid
    );

    modport slave (
        input  start_valid, op, a_in, b_in, done_ready,
        output start_ready, result, carry_out, zero, done_valid
    );

endinterface

// File: rtl/alu_mp_seq_alu.sv
// 8-bit combinational ALU: add, or add with carry-in.
// Ports: cin, ctrl_input, a, b in; out, cout, zero out.
module alu
    import alu_mp_seq_pkg::*;
(
    input  logic       cin,
    input  ALU_CTRL    ctrl_input,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out,
    output logic       cout,
    output logic       zero
);

    logic       cin_eff;
    logic [8:0] sum;

    always_comb begin
        cin_eff = 1'b0;
        unique case (ctrl_input)
            ALU_ADD:  cin_eff = 1'b0;
            ALU_ADDC: cin_eff = cin;
            default:  cin_eff = 1'b0;
        endcase
        sum  = {1'b0, a} + {1'b0, b} + {8'd0, cin_eff};
        out  = sum[7:0];
        cout = sum[8];
        zero = (sum[7:0] == 8'd0);
    end

endmodule

// File: rtl/alu_mp_seq.sv
// Multi-precision add/sub sequencer: one byte per cycle through the
// 8-bit ALU, LSB first. Ports: clk, reset, bus (slave handshake).
module alu_mp_seq
    import alu_mp_seq_pkg::*;
#(
    parameter int NBYTES = 4
)(
    input  logic         clk,
    input  logic         reset,
    alu_mp_seq_if.slave  bus
);

    localparam int IW = $clog2(NBYTES);
    localparam int OW = IW + 3;
    localparam int W  = 8 * NBYTES;

    mp_state_t     state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    MP_OP          op_q;
    logic [W-1:0]  res_q;
    logic          carry_q;
    logic          zacc_q;
    logic          dv_q;

    logic [OW-1:0] off;
    logic          first;
    logic          last;

    logic          alu_cin;
    ALU_CTRL       alu_ctrl;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [7:0]    alu_out;
    logic          alu_cout;
    logic          alu_zero;

    assign off   = {idx, 3'b000};
    assign first = (idx == '0);
    assign last  = (idx == IW'(NBYTES - 1));

    // SUB is A + ~B + 1: the +1 enters as carry-in on byte 0.
    always_comb begin
        alu_a    = a_q[off +: 8];
        alu_b    = b_q[off +: 8];
        alu_ctrl = ALU_ADDC;
        alu_cin  = carry_q;
        if (op_q == MP_SUB) begin
            alu_b = ~b_q[off +: 8];
            if (first) begin
                alu_cin = 1'b1;
            end
        end else if (first) begin
            alu_ctrl = ALU_ADD;
            alu_cin  = 1'b0;
        end
    end

    alu u_alu (
        .cin        (alu_cin),
        .ctrl_input (alu_ctrl),
        .a          (alu_a),
        .b          (alu_b),
        .out        (alu_out),
        .cout       (alu_cout),
        .zero       (alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MP_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MP_ADD;
            res_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            unique case (state)
                MP_IDLE: begin
                    if (bus.start_valid) begin
                        a_q   <= bus.a_in;
                        b_q   <= bus.b_in;
                        op_q  <= bus.op;
                        idx   <= '0;
                        state <= MP_RUN;
                    end
                end
                MP_RUN: begin
                    res_q[off +: 8] <= alu_out;
                    carry_q         <= alu_cout;
                    zacc_q          <= first ? alu_zero
                                             : (zacc_q & alu_zero);
                    if (last) begin
                        state <= MP_DONE;
                        dv_q  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                MP_DONE: begin
                    if (bus.done_ready) begin
                        state <= MP_IDLE;
                        dv_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= MP_IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = (state == MP_IDLE);
    assign bus.done_valid  = dv_q;
    assign bus.result      = res_q;
    assign bus.carry_out   = carry_q;
    assign bus.zero        = zacc_q;

endmodule

// File: tb/tb_alu_mp_seq.sv
// Self-checking bench for alu_mp_seq: directed corner cases plus
// random commands against an arithmetic reference model.
module tb_alu_mp_seq;
    import alu_mp_seq_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk;
    logic reset;

    int n_chk;
    int n_pass;

    alu_mp_seq_if #(.NBYTES(NB)) bus ();

    alu_mp_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the full operands.
    task automatic model(input MP_OP o, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] r,
                         output logic c, output logic z);
        logic [W:0] s;
        if (o == MP_ADD) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
        end else begin
            r = a - b;
            c = (a >= b);
        end
        z = (r == '0);
    endtask

    task automatic do_cmd(input MP_OP o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic         ec;
        logic         ez;
        int           lat;
        model(o, a, b, er, ec, ez);
        @(negedge clk);
        chk("idle_ready", bus.start_ready, 1);
        bus.start_valid = 1'b1;
        bus.op          = o;
        bus.a_in        = a;
        bus.b_in        = b;
        bus.done_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.a_in        = $urandom;
        bus.b_in        = $urandom;
        bus.op          = MP_OP'($urandom_range(0, 1));
        chk("run_ready", bus.start_ready, 0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done_valid && lat < 50);
        chk("latency", lat, NB);
        chk("result", bus.result, er);
        chk("carry", bus.carry_out, ec);
        chk("zero", bus.zero, ez);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.start_valid = 1'b1;
            bus.a_in        = $urandom;
            bus.b_in        = $urandom;
            @(posedge clk);
            #1;
            bus.start_valid = 1'b0;
            chk("bp_valid", bus.done_valid, 1);
            chk("bp_ready", bus.start_ready, 0);
            chk("bp_result", bus.result, er);
            chk("bp_flags", {bus.carry_out, bus.zero}, {ec, ez});
        end
        @(negedge clk);
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
        chk("ack_valid", bus.done_valid, 0);
        chk("ack_ready", bus.start_ready, 1);
        chk("hold_result", bus.result, er);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        bus.start_valid = 1'b0;
        bus.op          = MP_ADD;
        bus.a_in        = '0;
        bus.b_in        = '0;
        bus.done_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", bus.start_ready, 1);
        chk("rst_valid", bus.done_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.carry_out, bus.zero}, 2'b00);

        do_cmd(MP_ADD, 32'h0000_00FF, 32'h0000_0001, 0);
        do_cmd(MP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        do_cmd(MP_SUB, 32'h0000_0100, 32'h0000_0001, 0);
        do_cmd(MP_SUB, 32'h0000_0000, 32'h0000_0001, 0);
        do_cmd(MP_SUB, 32'h1234_5678, 32'h1234_5678, 0);
        do_cmd(MP_ADD, 32'h8000_0000, 32'h8000_0000, 5);

        // Reset mid-RUN after bytes 0 and 1 have been written.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op          = MP_ADD;
        bus.a_in        = 32'h0101_0101;
        bus.b_in        = 32'h0101_0101;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_result", bus.result[15:0], 16'h0202);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", bus.done_valid, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_flags", {bus.carry_out, bus.zero}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_ready", bus.start_ready, 1);
        do_cmd(MP_ADD, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) rb = ~ra;
            do_cmd(MP_OP'($urandom_range(0, 1)), ra, rb,
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_mp_seq.md
Name: alu_mp_seq

Overview:
- Multi-precision arithmetic sequencer. It performs NBYTES-wide add and subtract by issuing one 8-bit operation per cycle to the existing 8-bit ALU, least-significant byte first.
- It is the initiator side of the ALU interface: it drives cin, ctrl_input, a and b, then consumes out, cout and zero, chaining the carry between bytes.
- It sits between the datapath control and the ALU. It accepts a command with a valid/ready handshake and returns a full-width result with carry and zero flags.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_valid  in  1  a command is presented.
- start_ready  out  1  sequencer is idle and can accept a command.
- op  in  MP_OP (1)  MP_ADD or MP_SUB.
- a_in  in  8*NBYTES  operand A.
- b_in  in  8*NBYTES  operand B.
- result  out  8*NBYTES  A+B or A-B, modulo 2^(8*NBYTES).
- carry_out  out  1  final carry. For ADD it is the overflow carry; for SUB it is 1 when there is no borrow (A >= B unsigned).
- zero  out  1  1 when result == 0.
- done_valid  out  1  result, carry_out and zero are valid.
- done_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, any state, including mid-RUN or in DONE):
  - state goes to IDLE, byte index to 0.
  - result, carry_out, zero, done_valid and the internal carry register are cleared to 0.
  - start_ready = 1 once reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On a clock edge with start_valid=1, capture a_in, b_in and op; clear the byte index; go to RUN.
- RUN, in the cycle with byte index i:
  - ALU a = A[8i+7:8i].
  - ALU b = B byte for ADD; the bitwise inverse of the B byte for SUB.
  - ALU ctrl_input:
    - ADD, i=0: ALU_ADD (cin is don't-care; drive 0).
    - ADD, i>0: ALU_ADDC with cin = carry register.
    - SUB, i=0: ALU_ADDC with cin=1.
    - SUB, i>0: ALU_ADDC with cin = carry register.
  - At the edge:
    - write result byte i from the ALU out.
    - carry register <= ALU cout.
    - zero accumulator <= (i==0 ? ALU zero : accumulator & ALU zero).
    - increment i.
  - When i == NBYTES-1, go to DONE instead of incrementing.
  - start_ready = 0 throughout.
- Latency: a command accepted at edge k gives done_valid = 1 after edge k+NBYTES. There are exactly NBYTES RUN cycles.
- DONE:
  - done_valid = 1; carry_out = carry register; zero = zero accumulator.
  - result, carry_out and zero stay stable while done_ready = 0 (backpressure of unbounded length).
  - At an edge with done_ready = 1, go to IDLE and drop done_valid.
  - result and flags hold their last values in IDLE until the next command's first byte is written.
- No same-cycle restart. start_ready is combinationally equal to (state == IDLE). A new command is accepted at the earliest one cycle after the DONE handshake.
- start_valid is ignored outside IDLE. a_in, b_in and op may change freely after acceptance, because they are captured.
- ALU outputs are combinational. The sequencer registers everything and adds no path from start_valid or done_ready to its outputs other than start_ready.
- Widths:
  - byte index is $clog2(NBYTES) bits.
  - Operand and result registers are 8*NBYTES bits.
  - All arithmetic is performed only by the ALU; there are no wide adders in this block.

Decomposition:
- ALU_def package:
  - add typedef enum logic {MP_ADD, MP_SUB} MP_OP.
  - add typedef enum {MP_IDLE, MP_RUN, MP_DONE} mp_state_t.
  - reuse ALU_CTRL (ALU_ADD, ALU_ADDC).
- Sub-module: a single instance of the existing ALU, ports cin, ctrl_input, a, b, out, cout, zero. There is no other sub-module; the FSM and byte muxing live in alu_mp_seq.

Test Plan:
- NBYTES=4, MP_ADD 0x000000FF + 0x00000001 -> result 0x00000100, carry_out 0, zero 0; done_valid exactly 4 edges after accept.
- MP_ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out 1, zero 1. Carry must ripple through all 4 bytes.
- MP_SUB 0x00000100 - 0x00000001 -> result 0x000000FF, carry_out 1. MP_SUB 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, carry_out 0, zero 0.
- MP_SUB 0x12345678 - 0x12345678 -> result 0, carry_out 1, zero 1. MP_ADD 0x80000000 + 0x80000000 -> result 0, carry_out 1, zero 1.
- Backpressure: hold done_ready=0 for 5 cycles.
  - result, carry_out and zero are stable; start_ready=0; a start_valid pulse during DONE is ignored.
  - After done_ready=1: IDLE next cycle and a new command is accepted.
- Reset asserted asynchronously at byte 2 of a RUN:
  - immediately done_valid=0, result=0, carry_out=0, zero=0.
  - after release start_ready=1, and a following ADD 3+4 returns 7.
